// File: rtl/inst_rom_pkg.sv
// Shared definitions for the instruction ROM: default depth, FSM state
// encodings, data widths and the NOP word returned on gated fetches.
package inst_rom_pkg;

    // Data and address widths seen by the core.
    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BYTE_W = 8;

    // Default word-address width: 1024 x 32-bit words.
    localparam int unsigned ROM_DEPTH_LOG2_DEF = 10;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [INST_W-1:0] word_t;

    // Loader FSM encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    // Word returned whenever a fetch is gated off.
    localparam word_t NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/inst_rom_packer.sv
// Byte-to-word assembler. Bytes arrive most-significant first; the completed
// word is presented combinationally in the same cycle as its fourth byte so
// the caller can write it on that edge.
module inst_rom_packer
    import inst_rom_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_valid,
    input  byte_t      i_byte,
    output word_t      o_word,
    output logic       o_word_valid,
    output logic [1:0] o_byte_cnt
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    localparam logic [1:0] CNT_LAST = 2'd3;
    localparam logic [1:0] CNT_ONE  = 2'd1;

    // Shift accepted bytes in; the counter wraps to 0 after the fourth byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_valid) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_cnt   <= r_cnt + CNT_ONE;
        end
    end

    // Fourth byte completes the word in the current cycle.
    always_comb begin
        o_word       = {r_shift, i_byte};
        o_word_valid = i_valid && !i_clear && (r_cnt == CNT_LAST);
        o_byte_cnt   = r_cnt;
    end

endmodule

// File: rtl/inst_rom.sv
// Loadable instruction ROM. The core fetches combinationally while the loader
// is idle; a byte-stream loader fills the memory from word 0 upward.
// Optional feature: define INST_ROM_CHECKSUM_EN to keep a running XOR of all
// words written during the current load; otherwise load_checksum is 0.
module inst_rom
    import inst_rom_pkg::*;
#(
    parameter int unsigned ROM_DEPTH_LOG2 = ROM_DEPTH_LOG2_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rom_en,
    input  logic [ADDR_W-1:0]       rom_addr,
    output logic [INST_W-1:0]       rom_inst,
    input  logic                    load_start,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [BYTE_W-1:0]       load_byte,
    input  logic                    load_finish,
    output logic                    load_busy,
    output logic                    load_err,
    output logic [ROM_DEPTH_LOG2:0] load_words,
    output logic [INST_W-1:0]       load_checksum
);

    localparam int unsigned DEPTH = 1 << ROM_DEPTH_LOG2;

    localparam logic [ROM_DEPTH_LOG2-1:0] PTR_LAST  = '1;
    localparam logic [ROM_DEPTH_LOG2-1:0] PTR_ONE   = {{(ROM_DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [ROM_DEPTH_LOG2:0]   WORDS_ONE = {{ROM_DEPTH_LOG2{1'b0}}, 1'b1};

    logic [1:0]                r_state;
    logic [1:0]                w_state_next;
    logic [ROM_DEPTH_LOG2-1:0] r_ptr;
    logic [ROM_DEPTH_LOG2-1:0] w_ptr_next;
    logic [ROM_DEPTH_LOG2:0]   r_words;
    logic [ROM_DEPTH_LOG2:0]   w_words_next;
    logic                      r_err;
    logic                      w_err_next;

    logic  w_accept;
    logic  w_clear;
    logic  w_finish_act;
    word_t w_word;
    logic  w_word_valid;
    logic [1:0] w_byte_cnt;

    word_t r_mem [DEPTH];

    // Byte offset within a word never selects anything.
    logic w_unused_addr_lo;
    assign w_unused_addr_lo = ^rom_addr[1:0];

    // A finish only matters while a load is in progress.
    assign w_finish_act = load_finish && (r_state != ST_IDLE);

    // Start and finish both take precedence over a byte in the same cycle.
    assign w_accept = load_valid && (r_state == ST_LOAD) && !load_start && !load_finish;
    assign w_clear  = load_start || w_finish_act;

    inst_rom_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_valid      (w_accept),
        .i_byte       (load_byte),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_byte_cnt   (w_byte_cnt)
    );

    // Loader next-state: start beats finish, finish beats a word write.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_words_next = r_words;
        w_err_next   = r_err;
        if (load_start) begin
            w_state_next = ST_LOAD;
            w_ptr_next   = '0;
            w_words_next = '0;
            w_err_next   = 1'b0;
        end else if (w_finish_act) begin
            w_state_next = ST_IDLE;
            if (w_byte_cnt != 2'd0) begin
                w_err_next = 1'b1;
            end
        end else if (w_word_valid) begin
            w_ptr_next   = r_ptr + PTR_ONE;
            w_words_next = r_words + WORDS_ONE;
            if (r_ptr == PTR_LAST) begin
                w_state_next = ST_FULL;
            end
        end
    end

    // Loader control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_words <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_words <= w_words_next;
            r_err   <= w_err_next;
        end
    end

    // Program storage is deliberately not reset so a reset keeps the program.
    always_ff @(posedge clk) begin
        if (w_word_valid) begin
            r_mem[r_ptr] <= w_word;
        end
    end

`ifdef INST_ROM_CHECKSUM_EN
    word_t r_checksum;

    // Running XOR of every word written since the last start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (load_start) begin
            r_checksum <= '0;
        end else if (w_word_valid) begin
            r_checksum <= r_checksum ^ w_word;
        end
    end

    assign load_checksum = r_checksum;
`else
    assign load_checksum = NOP_WORD;
`endif

    // Fetch port: only served while idle and inside the implemented range.
    always_comb begin
        rom_inst = NOP_WORD;
        if (rom_en && (r_state == ST_IDLE) && (rom_addr[ADDR_W-1:ROM_DEPTH_LOG2+2] == '0)) begin
            rom_inst = r_mem[rom_addr[ROM_DEPTH_LOG2+1:2]];
        end
    end

    // Status outputs.
    always_comb begin
        load_ready = (r_state == ST_LOAD);
        load_busy  = (r_state != ST_IDLE);
        load_err   = r_err;
        load_words = r_words;
    end

endmodule

// File: tb/tb_inst_rom.sv
// Directed self-checking bench for inst_rom at depth 10.
module tb_inst_rom;

    logic        clk;
    logic        rst;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        load_start;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_byte;
    logic        load_finish;
    logic        load_busy;
    logic        load_err;
    logic [10:0] load_words;
    logic [31:0] load_checksum;

    int checks;
    int errors;

    inst_rom #(.ROM_DEPTH_LOG2(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_en        (rom_en),
        .rom_addr      (rom_addr),
        .rom_inst      (rom_inst),
        .load_start    (load_start),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_byte     (load_byte),
        .load_finish   (load_finish),
        .load_busy     (load_busy),
        .load_err      (load_err),
        .load_words    (load_words),
        .load_checksum (load_checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic pulse_finish();
        load_finish = 1'b1;
        tick();
        load_finish = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        rom_en   = 1'b1;
        rom_addr = a;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", load_ready); end
        checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", load_busy); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", load_err); end
        checks++; if (load_words !== 11'd0) begin errors++; $display("FAIL reset_words: got %0d want 0", load_words); end
        checks++; if (load_checksum !== 32'h0) begin errors++; $display("FAIL reset_checksum: got %h want 0", load_checksum); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        pulse_start();
        checks++; if (load_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0b want 1", load_busy); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %0b want 1", load_ready); end
        send_byte(8'h24);
        fetch(32'h0);
        checks++; if (rom_inst !== 32'h0) begin errors++; $display("FAIL fetch_in_load: got %h want 00000000", rom_inst); end
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h05);
        checks++; if (load_words !== 11'd1) begin errors++; $display("FAIL single_words_live: got %0d want 1", load_words); end
        pulse_finish();
        checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %0b want 0", load_busy); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL single_err: got %0b want 0", load_err); end
        checks++; if (load_words !== 11'd1) begin errors++; $display("FAIL single_words: got %0d want 1", load_words); end
        fetch(32'h0);
        checks++; if (rom_inst !== 32'h2402_0005) begin errors++; $display("FAIL single_fetch: got %h want 24020005", rom_inst); end
        fetch(32'h3);
        checks++; if (rom_inst !== 32'h2402_0005) begin errors++; $display("FAIL fetch_lowbits: got %h want 24020005", rom_inst); end
    endtask

    task automatic test_fetch_gating();
        rom_en = 1'b0; rom_addr = 32'h0; #1;
        checks++; if (rom_inst !== 32'h0) begin errors++; $display("FAIL fetch_disabled: got %h want 00000000", rom_inst); end
        fetch(32'h0000_1000);
        checks++; if (rom_inst !== 32'h0) begin errors++; $display("FAIL fetch_range: got %h want 00000000", rom_inst); end
        fetch(32'h8000_0000);
        checks++; if (rom_inst !== 32'h0) begin errors++; $display("FAIL fetch_msb: got %h want 00000000", rom_inst); end
    endtask

    task automatic test_partial();
        pulse_start();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
        pulse_finish();
        checks++; if (load_words !== 11'd1) begin errors++; $display("FAIL partial_words: got %0d want 1", load_words); end
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL partial_err: got %0b want 1", load_err); end
        checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL partial_idle: got %0b want 0", load_busy); end
        fetch(32'h0);
        checks++; if (rom_inst !== 32'h1122_3344) begin errors++; $display("FAIL partial_fetch: got %h want 11223344", rom_inst); end
    endtask

    task automatic test_checksum();
        logic [31:0] exp_sum;
`ifdef INST_ROM_CHECKSUM_EN
        exp_sum = 32'hEDCB_5678;
`else
        exp_sum = 32'h0;
`endif
        pulse_start();
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL start_clears_err: got %0b want 0", load_err); end
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        tick();
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h00); send_byte(8'h00);
        checks++; if (load_words !== 11'd2) begin errors++; $display("FAIL csum_words: got %0d want 2", load_words); end
        checks++; if (load_checksum !== exp_sum) begin errors++; $display("FAIL csum_value: got %h want %h", load_checksum, exp_sum); end
        pulse_finish();
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL csum_err: got %0b want 0", load_err); end
        fetch(32'h0);
        checks++; if (rom_inst !== 32'h1234_5678) begin errors++; $display("FAIL csum_fetch0: got %h want 12345678", rom_inst); end
        fetch(32'h4);
        checks++; if (rom_inst !== 32'hFFFF_0000) begin errors++; $display("FAIL csum_fetch1: got %h want ffff0000", rom_inst); end
    endtask

    task automatic test_finish_drop();
        pulse_start();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        load_valid = 1'b1; load_byte = 8'hDD; load_finish = 1'b1;
        tick();
        load_valid = 1'b0; load_finish = 1'b0;
        checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got %0b want 0", load_busy); end
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL drop_err: got %0b want 1", load_err); end
        checks++; if (load_words !== 11'd0) begin errors++; $display("FAIL drop_words: got %0d want 0", load_words); end
        fetch(32'h0);
        checks++; if (rom_inst !== 32'h1234_5678) begin errors++; $display("FAIL drop_mem: got %h want 12345678", rom_inst); end
    endtask

    task automatic test_start_wins();
        logic [31:0] exp_sum;
`ifdef INST_ROM_CHECKSUM_EN
        exp_sum = 32'h9ABC_DEF0;
`else
        exp_sum = 32'h0;
`endif
        pulse_start();
        send_byte(8'h01); send_byte(8'h02);
        load_start = 1'b1; load_finish = 1'b1;
        tick();
        load_start = 1'b0; load_finish = 1'b0;
        checks++; if (load_busy !== 1'b1) begin errors++; $display("FAIL both_busy: got %0b want 1", load_busy); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL both_err: got %0b want 0", load_err); end
        send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
        pulse_finish();
        checks++; if (load_words !== 11'd1) begin errors++; $display("FAIL restart_words: got %0d want 1", load_words); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL restart_err: got %0b want 0", load_err); end
        checks++; if (load_checksum !== exp_sum) begin errors++; $display("FAIL restart_csum: got %h want %h", load_checksum, exp_sum); end
        fetch(32'h0);
        checks++; if (rom_inst !== 32'h9ABC_DEF0) begin errors++; $display("FAIL restart_fetch0: got %h want 9abcdef0", rom_inst); end
        fetch(32'h4);
        checks++; if (rom_inst !== 32'hFFFF_0000) begin errors++; $display("FAIL restart_keep1: got %h want ffff0000", rom_inst); end
    endtask

    task automatic test_ignored();
        pulse_finish();
        checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL idle_finish_busy: got %0b want 0", load_busy); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL idle_finish_err: got %0b want 0", load_err); end
        send_byte(8'h55); send_byte(8'h55); send_byte(8'h55); send_byte(8'h55);
        checks++; if (load_words !== 11'd1) begin errors++; $display("FAIL idle_valid_words: got %0d want 1", load_words); end
        fetch(32'h0);
        checks++; if (rom_inst !== 32'h9ABC_DEF0) begin errors++; $display("FAIL idle_valid_mem: got %h want 9abcdef0", rom_inst); end
    endtask

    task automatic test_reset_midload();
        pulse_start();
        send_byte(8'h01); send_byte(8'h02);
        rst = 1'b1;
        #1;
        checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %0b want 0", load_busy); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rst_async_ready: got %0b want 0", load_ready); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (load_words !== 11'd0) begin errors++; $display("FAIL rst_words: got %0d want 0", load_words); end
        checks++; if (load_checksum !== 32'h0) begin errors++; $display("FAIL rst_csum: got %h want 0", load_checksum); end
        fetch(32'h0);
        checks++; if (rom_inst !== 32'h9ABC_DEF0) begin errors++; $display("FAIL rst_mem: got %h want 9abcdef0", rom_inst); end
    endtask

    task automatic test_full();
        logic [31:0] w;
        logic [31:0] exp_sum;
        exp_sum = 32'h0;
        pulse_start();
        for (int i = 0; i < 1024; i++) begin
            w = 32'hC0DE_0000 | i;
`ifdef INST_ROM_CHECKSUM_EN
            exp_sum = exp_sum ^ w;
`endif
            send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]);
            if (i == 1023) begin
                checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL full_ready_early: got %0b want 1", load_ready); end
            end
            send_byte(w[7:0]);
        end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", load_ready); end
        checks++; if (load_busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %0b want 1", load_busy); end
        checks++; if (load_words !== 11'd1024) begin errors++; $display("FAIL full_words: got %0d want 1024", load_words); end
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        checks++; if (load_words !== 11'd1024) begin errors++; $display("FAIL full_ignore: got %0d want 1024", load_words); end
        checks++; if (load_checksum !== exp_sum) begin errors++; $display("FAIL full_csum: got %h want %h", load_checksum, exp_sum); end
        pulse_finish();
        checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL full_idle: got %0b want 0", load_busy); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL full_err: got %0b want 0", load_err); end
        fetch(32'h0000_0FFC);
        checks++; if (rom_inst !== 32'hC0DE_03FF) begin errors++; $display("FAIL full_last: got %h want c0de03ff", rom_inst); end
        fetch(32'h0000_0004);
        checks++; if (rom_inst !== 32'hC0DE_0001) begin errors++; $display("FAIL full_word1: got %h want c0de0001", rom_inst); end
        fetch(32'h0000_0000);
        checks++; if (rom_inst !== 32'hC0DE_0000) begin errors++; $display("FAIL full_word0: got %h want c0de0000", rom_inst); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        rom_en      = 1'b0;
        rom_addr    = 32'h0;
        load_start  = 1'b0;
        load_valid  = 1'b0;
        load_byte   = 8'h00;
        load_finish = 1'b0;
        test_reset();
        test_single_word();
        test_fetch_gating();
        test_partial();
        test_checksum();
        test_finish_drop();
        test_start_wins();
        test_ignored();
        test_reset_midload();
        test_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
